// File: rtl/double_divide_arbiter_if.sv
// Bundle shared by the arbiter, its requesters and the shared divider.
// The arbiter uses the master modport; the requesters and the divider use slave.
interface double_divide_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [63:0]      req_dividend [N_REQ];
    logic [63:0]      req_divisor  [N_REQ];
    logic [N_REQ-1:0] ack;
    logic [63:0]      result;
    logic             result_valid;
    logic [IDW-1:0]   result_id;
    logic [1:0]       result_err;
    logic             busy;
    logic             div_start;
    logic [63:0]      div_dividend;
    logic [63:0]      div_divisor;
    logic [63:0]      div_quotient;
    logic             div_valid;

    modport master (
        input  req, req_dividend, req_divisor, div_quotient, div_valid,
        output ack, result, result_valid, result_id, result_err, busy,
               div_start, div_dividend, div_divisor
    );

    modport slave (
        output req, req_dividend, req_divisor, div_quotient, div_valid,
        input  ack, result, result_valid, result_id, result_err, busy,
               div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/double_divide_arbiter.sv
// Round-robin front end that shares one double-precision divider between N_REQ
// requesters; zero divisors are answered locally with a signed infinity.
module double_divide_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    double_divide_arbiter_if.master bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

    state_t           state_q;
    logic [IDW-1:0]   last_grant_q;
    logic [IDW-1:0]   cur_id_q;
    logic [63:0]      dividend_q;
    logic [63:0]      divisor_q;
    logic [N_REQ-1:0] ack_q;
    logic             div_start_q;
    logic [63:0]      result_q;
    logic             result_valid_q;
    logic [IDW-1:0]   result_id_q;
    logic [1:0]       result_err_q;
    logic             busy_q;
    logic [CW-1:0]    cnt_q;

    logic             grant_found_d;
    logic [IDW-1:0]   grant_id_d;
    logic [IDW:0]     cand;
    logic [N_REQ-1:0] grant_onehot_d;
    logic [63:0]      sel_dividend;
    logic [63:0]      sel_divisor;
    logic             sel_div_zero;

    // Scan downward in distance so the nearest requester after last_grant wins;
    // last_grant itself is considered last.
    always_comb begin
        grant_found_d = 1'b0;
        grant_id_d    = '0;
        cand          = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, last_grant_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (bus.req[cand[IDW-1:0]]) begin
                grant_found_d = 1'b1;
                grant_id_d    = cand[IDW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign grant_onehot_d[gi] = (grant_id_d == IDW'(gi));
        end
    endgenerate

    assign sel_dividend = bus.req_dividend[grant_id_d];
    assign sel_divisor  = bus.req_divisor[grant_id_d];
    assign sel_div_zero = (sel_divisor[62:0] == 63'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            last_grant_q   <= IDW'(N_REQ - 1);
            cur_id_q       <= '0;
            dividend_q     <= '0;
            divisor_q      <= '0;
            ack_q          <= '0;
            div_start_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_err_q   <= 2'b00;
            busy_q         <= 1'b0;
            cnt_q          <= '0;
        end else begin
            ack_q          <= '0;
            div_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_found_d) begin
                        cur_id_q   <= grant_id_d;
                        dividend_q <= sel_dividend;
                        divisor_q  <= sel_divisor;
                        ack_q      <= grant_onehot_d;
                        busy_q     <= 1'b1;
                        if (sel_div_zero) begin
                            result_q       <= {sel_dividend[63] ^ sel_divisor[63], 11'h7FF, 52'h0};
                            result_err_q   <= 2'b01;
                            result_valid_q <= 1'b1;
                            result_id_q    <= grant_id_d;
                            state_q        <= S_RESPOND;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.div_valid) begin
                        result_q       <= bus.div_quotient;
                        result_err_q   <= 2'b00;
                        result_valid_q <= 1'b1;
                        result_id_q    <= cur_id_q;
                        state_q        <= S_RESPOND;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        result_q       <= '0;
                        result_err_q   <= 2'b10;
                        result_valid_q <= 1'b1;
                        result_id_q    <= cur_id_q;
                        state_q        <= S_RESPOND;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESPOND: begin
                    last_grant_q <= cur_id_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ack          = ack_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_id    = result_id_q;
    assign bus.result_err   = result_err_q;
    assign bus.busy         = busy_q;
    assign bus.div_start    = div_start_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
endmodule
